// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   XLEN, INSTR_BYTES : machine word width and instruction size in bytes
//   fetch_entry_t     : one prefetch-buffer slot, an instruction word and its PC
//   align_pc          : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: registered synchronous FIFO, generic over the entry type.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data this cycle (ignored when full unless popping)
//   push_data : entry to write
//   pop       : remove the head entry this cycle (ignored when empty)
//   flush     : empty the FIFO; wins over push and pop in the same cycle
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries, 0..DEPTH
//   head      : oldest entry, read straight from the storage registers
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter type entry_t = logic [31:0],
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end feeding decode.
//   clk, rst                      : clock, synchronous active-high reset
//   imem_req_valid/ready/addr     : word-aligned read requests to instruction memory
//   imem_rsp_valid/data           : in-order read responses, always accepted
//   redirect_valid/redirect_pc    : restart fetch at a new PC (low two bits ignored)
//   instr_valid/ready, instr, instr_pc : head of the prefetch buffer towards decode
//
// Handshakes: a transfer happens in a cycle where valid && ready are both high
// at the rising edge. The request channel carries no stability promise:
// imem_req_valid may fall before acceptance and the address is only meaningful
// in a fire cycle. imem_rsp_valid has no ready; every response is taken.
//
// Requests are only issued when the buffer is guaranteed room for the kept
// response: fifo entries plus live (non-discarded) outstanding requests stay
// below DEPTH. After a redirect, responses still in flight for the old stream
// are counted in discard and dropped on arrival.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CRW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  logic [CRW-1:0] credit_used;
  logic           req_fire;
  logic [31:0]    target_pc;

  // Discarded requests will never occupy a slot, so they do not consume credit.
  assign credit_used = CRW'(fifo_count) + CRW'(outstanding_q) - CRW'(discard_q);

  assign imem_req_valid = !rst && !redirect_valid
                          && (outstanding_q < OW'(MAX_OUTSTANDING))
                          && (credit_used < CRW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign target_pc      = align_pc(redirect_pc);

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_head.instr;
  assign instr_pc    = fifo_head.pc;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    rsp_pc_d         = rsp_pc_q;
    outstanding_d    = outstanding_q;
    discard_d        = discard_q;
    fifo_push        = 1'b0;
    fifo_flush       = 1'b0;
    fifo_pop         = instr_valid && instr_ready;
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = rsp_pc_q;

    if (redirect_valid) begin
      // A response landing in the redirect cycle belongs to the old stream and
      // is dropped here, so it is not counted again in discard.
      fifo_flush    = 1'b1;
      fetch_pc_d    = target_pc;
      rsp_pc_d      = target_pc;
      outstanding_d = outstanding_q - OW'(imem_rsp_valid);
      discard_d     = outstanding_q - OW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      end
      outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'(INSTR_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .entry_t (fetch_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural in-order memory with selectable latency,
// a next-PC stream model plus an expected-PC queue for the redirect table,
// and hand-written sequences for reset, stall and redirect corner cases.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    lat;
  int    cyc;
  int    max_os;
  int    fires;
  int    pops;

  // scoreboard
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } redir_vec_t;
  redir_vec_t vec[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: sample at negedge, update the memory after the posedge.
  task automatic tick();
    logic        fire_s;
    logic [31:0] addr_s;
    logic        rsp_s;
    @(negedge clk);
    fire_s = imem_req_valid && imem_req_ready;
    addr_s = imem_req_addr;
    rsp_s  = imem_rsp_valid;
    if (rst) begin
      exp_pc = 32'h0;
    end else begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_data", instr, mem_word(instr_pc));
        if (exp_q.size() > 0) chk("queue_pc", instr_pc, exp_q.pop_front());
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      if (fire_s) begin
        fires++;
        if (addr_s[1:0] != 2'b00) chk("req_align", {30'd0, addr_s[1:0]}, 32'd0);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
    end else begin
      if (rsp_s) void'(mq.pop_front());
      if (fire_s) mq.push_back('{addr_s, cyc + lat - 1});
    end
    if (mq.size() > max_os) max_os = mq.size();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_exp(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d expected PCs never delivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    lat            = 1;
    max_os         = 0;
    fires          = 0;
    pops           = 0;
    exp_pc         = 32'h0;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;

    vec[0] = '{32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vec[1] = '{32'h0000_0103, 1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vec[2] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vec[3] = '{32'h0000_02A6, 2, 32'h0000_02A4, 32'h0000_02A4, 32'h0000_02A8};
    vec[4] = '{32'h0000_0010, 1, 32'h0000_0010, 32'h0000_0010, 32'h0000_0014};

    // Reset values and startup timing.
    run(2);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c0_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("c1_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("c2_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("c2_instr_pc", instr_pc, 32'h0);
    pops = 0;
    run(10);
    chk("throughput_pops", pops, 32'd10);

    // Decode stalled for 20 cycles: buffer fills to DEPTH, then fetch stops.
    do_reset();
    instr_ready = 1'b0;
    fires = 0;
    run(20);
    chk("stall_fires", fires, 32'd4);
    chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_inflight", mq.size(), 32'd0);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    pops = 0;
    run(4);
    chk("release_pops", pops, 32'd4);
    wait_exp("release_order");
    run(4);

    // Redirect table: target alignment, stale responses dropped, wrap.
    for (int t = 0; t < 5; t++) begin
      lat = vec[t].lat;
      run(6);
      if (vec[t].lat > 1) begin
        int n;
        n = 0;
        while (mq.size() < 2 && n < 20) begin
          tick();
          n++;
        end
        chk("two_in_flight", (mq.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
      end
      exp_q.delete();
      exp_q.push_back(vec[t].exp0);
      exp_q.push_back(vec[t].exp1);
      redirect_valid = 1'b1;
      redirect_pc    = vec[t].pc;
      #1;
      chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      chk("redir_req_addr", imem_req_addr, vec[t].exp_addr);
      chk("redir_flushed", {31'd0, instr_valid}, 32'd0);
      wait_exp("redir_table");
    end

    // Redirect coinciding with a response and a pop.
    lat = 2;
    run(6);
    begin
      int n;
      n = 0;
      while (!(imem_rsp_valid && instr_valid) && n < 20) begin
        tick();
        n++;
      end
      chk("rsp_pop_cycle_found", {31'd0, imem_rsp_valid && instr_valid}, 32'd1);
    end
    exp_q.push_back(32'h0000_0400);
    exp_q.push_back(32'h0000_0404);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    wait_exp("redir_with_rsp_pop");

    // Back-to-back redirects: only the second stream survives.
    lat = 3;
    run(6);
    exp_q.push_back(32'h0000_0300);
    exp_q.push_back(32'h0000_0304);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    wait_exp("redir_back_to_back");

    // Reset in the middle of traffic.
    lat = 1;
    run(5);
    rst = 1'b1;
    tick();
    chk("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_req_addr", imem_req_addr, 32'h0);
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    wait_exp("midrst_restart");
    run(4);

    chk("max_outstanding", (max_os <= 2) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
